// File: rtl/nco_sweep_pkg.sv
// Shared definitions for the NCO sweep controller family.
// - State encoding for the sweep FSM.
// - Phase-increment clamp helper. Values are zero-extended to MaxIncW bits so
//   any increment width up to 32 bits can reuse it.
package nco_sweep_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_LAST  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = S_IDLE,
    StSweep = S_SWEEP,
    StLast  = S_LAST
  } sweep_state_e;

  localparam int unsigned MaxIncW = 32;

  // Returns stop when the candidate overran it in the sweep direction, or
  // when the step arithmetic carried/borrowed. The sweep never wraps.
  function automatic logic [MaxIncW-1:0] clamp_inc(input logic [MaxIncW-1:0] nxt,
                                                   input logic [MaxIncW-1:0] stop,
                                                   input logic               up,
                                                   input logic               carry);
    logic [MaxIncW-1:0] res;
    res = nxt;
    if (carry) begin
      res = stop;
    end else if (up && (nxt > stop)) begin
      res = stop;
    end else if (!up && (nxt < stop)) begin
      res = stop;
    end
    return res;
  endfunction

endpackage

// File: rtl/nco_sweep_dwell_cnt.sv
// Loadable dwell down-counter.
// Ports:
//   clk, reset  - clock, async active-high reset (count clears to 0)
//   clken       - enable; the counter holds when low
//   load        - load load_val (takes priority over counting)
//   load_val    - reload value
//   cnt         - current count
//   zero        - high when cnt == 0
// Counts down by one per enabled cycle and stops at zero.
module nco_sweep_dwell_cnt #(
  parameter int unsigned dwr = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clken,
  input  logic           load,
  input  logic [dwr-1:0] load_val,
  output logic [dwr-1:0] cnt,
  output logic           zero
);

  logic [dwr-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clken) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped linear frequency sweep (chirp) sequencer feeding phi_inc_i of nco_st.
// Ports:
//   clk, reset            - clock, async active-high reset
//   clken                 - NCO clock enable; all state advances only when high
//   start, abort, rpt     - start pulse, abort (highest priority), repeat mode
//   start_inc, stop_inc   - first/last phase increment (latched at start)
//   step_inc              - step magnitude (latched at start)
//   dwell                 - each frequency lasts dwell+1 enabled cycles
//   phi_inc_o             - registered phase increment to the NCO
//   busy, done, dir_o     - sweeping, end-of-pass pulse, 1 = up-sweep
module nco_sweep_ctrl
  import nco_sweep_pkg::*;
#(
  parameter int unsigned apr = 16,
  parameter int unsigned dwr = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clken,
  input  logic           start,
  input  logic           abort,
  input  logic           rpt,
  input  logic [apr-1:0] start_inc,
  input  logic [apr-1:0] stop_inc,
  input  logic [apr-1:0] step_inc,
  input  logic [dwr-1:0] dwell,
  output logic [apr-1:0] phi_inc_o,
  output logic           busy,
  output logic           done,
  output logic           dir_o
);

  sweep_state_e   state_q, state_d;
  logic [apr-1:0] phi_q, phi_d;
  logic [apr-1:0] start_q, start_d;
  logic [apr-1:0] stop_q, stop_d;
  logic [apr-1:0] step_q, step_d;
  logic [dwr-1:0] dwell_q, dwell_d;
  logic           rpt_q, rpt_d;
  logic           dir_q, dir_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           cnt_load;
  logic [dwr-1:0] cnt_val;
  logic [dwr-1:0] cnt;
  logic           cnt_zero;

  // Step arithmetic is one bit wider so the carry/borrow is visible.
  logic [apr:0]         sum, diff, raw;
  logic [MaxIncW-1:0]   clamp_full;
  logic [apr-1:0]       next_inc;

  always_comb begin
    sum        = {1'b0, phi_q} + {1'b0, step_q};
    diff       = {1'b0, phi_q} - {1'b0, step_q};
    raw        = dir_q ? sum : diff;
    clamp_full = clamp_inc(MaxIncW'(raw[apr-1:0]), MaxIncW'(stop_q), dir_q, raw[apr]);
    // A zero step would never reach stop; jump straight there instead.
    next_inc   = (step_q == '0) ? stop_q : clamp_full[apr-1:0];
  end

  if (apr < MaxIncW) begin : g_unused_hi
    logic unused_clamp_hi;
    assign unused_clamp_hi = ^clamp_full[MaxIncW-1:apr];
  end

  nco_sweep_dwell_cnt #(
    .dwr(dwr)
  ) u_dwell_cnt (
    .clk     (clk),
    .reset   (reset),
    .clken   (clken),
    .load    (cnt_load),
    .load_val(cnt_val),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  logic unused_cnt;
  assign unused_cnt = ^cnt;

  always_comb begin
    state_d  = state_q;
    phi_d    = phi_q;
    start_d  = start_q;
    stop_d   = stop_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    rpt_d    = rpt_q;
    dir_d    = dir_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = dwell_q;

    if (abort) begin
      // phi_inc_o deliberately holds so the NCO keeps its last frequency.
      state_d = StIdle;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            start_d  = start_inc;
            stop_d   = stop_inc;
            step_d   = step_inc;
            dwell_d  = dwell;
            rpt_d    = rpt;
            dir_d    = (start_inc <= stop_inc);
            phi_d    = start_inc;
            busy_d   = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = dwell;
            state_d  = StSweep;
          end
        end
        StSweep: begin
          if (cnt_zero) begin
            phi_d    = next_inc;
            cnt_load = 1'b1;
            if (next_inc == stop_q) begin
              state_d = StLast;
            end
          end
        end
        StLast: begin
          if (cnt_zero) begin
            done_d = 1'b1;
            if (rpt_q) begin
              phi_d    = start_q;
              cnt_load = 1'b1;
              state_d  = StSweep;
            end else begin
              busy_d  = 1'b0;
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      phi_q   <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      rpt_q   <= 1'b0;
      dir_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (clken) begin
      state_q <= state_d;
      phi_q   <= phi_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      rpt_q   <= rpt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign phi_inc_o = phi_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dir_o     = dir_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: expected per-sample (phi, busy, done)
// tuples are queued when a sweep is kicked off and popped one per observed
// sample.
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        clken;
  logic        start;
  logic        abort;
  logic        rpt;
  logic [15:0] start_inc;
  logic [15:0] stop_inc;
  logic [15:0] step_inc;
  logic [15:0] dwell;
  logic [15:0] phi_inc_o;
  logic        busy;
  logic        done;
  logic        dir_o;

  always #5 clk = ~clk;

  nco_sweep_ctrl #(
    .apr(16),
    .dwr(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clken    (clken),
    .start    (start),
    .abort    (abort),
    .rpt      (rpt),
    .start_inc(start_inc),
    .stop_inc (stop_inc),
    .step_inc (step_inc),
    .dwell    (dwell),
    .phi_inc_o(phi_inc_o),
    .busy     (busy),
    .done     (done),
    .dir_o    (dir_o)
  );

  typedef struct packed {
    logic [15:0] phi;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] v, input int reps, input logic b, input logic d);
    exp_t e;
    e.phi  = v;
    e.busy = b;
    e.done = d;
    for (int i = 0; i < reps; i++) sb.push_back(e);
  endtask

  // Compare one queued entry per enabled cycle. With gated set, clken runs
  // 0,1,0,1 so each entry must stay visible for two clocks.
  task automatic drain(input string tag, input bit gated);
    exp_t e;
    int   n;
    n = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      for (int k = 0; k < (gated ? 2 : 1); k++) begin
        if (gated) clken = (k == 1);
        chk($sformatf("%s[%0d].phi", tag, n), 32'(phi_inc_o), 32'(e.phi));
        chk($sformatf("%s[%0d].busy", tag, n), 32'(busy), 32'(e.busy));
        chk($sformatf("%s[%0d].done", tag, n), 32'(done), 32'(e.done));
        @(posedge clk);
        #1;
      end
      n++;
    end
    clken = 1'b1;
  endtask

  task automatic kick(input logic [15:0] s, input logic [15:0] e, input logic [15:0] st,
                      input logic [15:0] dw, input logic r);
    start_inc = s;
    stop_inc  = e;
    step_inc  = st;
    dwell     = dw;
    rpt       = r;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    // Scramble inputs: latched copies must be used for the rest of the pass.
    start_inc = 16'h1234;
    stop_inc  = 16'h0001;
    step_inc  = 16'h0003;
    dwell     = 16'h0005;
    rpt       = ~r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    clken     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    rpt       = 1'b0;
    start_inc = '0;
    stop_inc  = '0;
    step_inc  = '0;
    dwell     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.phi", 32'(phi_inc_o), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.done", 32'(done), 32'h0);
    chk("rst.dir", 32'(dir_o), 32'h1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Up-sweep, dwell 2.
    kick(16'd100, 16'd130, 16'd10, 16'd2, 1'b0);
    chk("up.dir", 32'(dir_o), 32'h1);
    push(16'd100, 3, 1'b1, 1'b0);
    push(16'd110, 3, 1'b1, 1'b0);
    push(16'd120, 3, 1'b1, 1'b0);
    push(16'd130, 3, 1'b1, 1'b0);
    push(16'd130, 1, 1'b0, 1'b1);
    push(16'd130, 2, 1'b0, 1'b0);
    drain("up", 1'b0);

    // Overshoot clamp.
    kick(16'd100, 16'd125, 16'd10, 16'd0, 1'b0);
    push(16'd100, 1, 1'b1, 1'b0);
    push(16'd110, 1, 1'b1, 1'b0);
    push(16'd120, 1, 1'b1, 1'b0);
    push(16'd125, 1, 1'b1, 1'b0);
    push(16'd125, 1, 1'b0, 1'b1);
    push(16'd125, 1, 1'b0, 1'b0);
    drain("clamp", 1'b0);

    // Down-sweep with clamp.
    kick(16'd500, 16'd480, 16'd7, 16'd0, 1'b0);
    chk("down.dir", 32'(dir_o), 32'h0);
    push(16'd500, 1, 1'b1, 1'b0);
    push(16'd493, 1, 1'b1, 1'b0);
    push(16'd486, 1, 1'b1, 1'b0);
    push(16'd480, 1, 1'b1, 1'b0);
    push(16'd480, 1, 1'b0, 1'b1);
    push(16'd480, 1, 1'b0, 1'b0);
    drain("down", 1'b0);

    // Carry must clamp, never wrap to 0x0010.
    kick(16'hFFF0, 16'hFFFF, 16'h0020, 16'd0, 1'b0);
    chk("wrap.dir", 32'(dir_o), 32'h1);
    push(16'hFFF0, 1, 1'b1, 1'b0);
    push(16'hFFFF, 1, 1'b1, 1'b0);
    push(16'hFFFF, 1, 1'b0, 1'b1);
    push(16'hFFFF, 1, 1'b0, 1'b0);
    drain("nowrap", 1'b0);

    // Zero step jumps to stop after the first dwell.
    kick(16'd100, 16'd130, 16'd0, 16'd0, 1'b0);
    push(16'd100, 1, 1'b1, 1'b0);
    push(16'd130, 1, 1'b1, 1'b0);
    push(16'd130, 1, 1'b0, 1'b1);
    push(16'd130, 1, 1'b0, 1'b0);
    drain("step0", 1'b0);

    // clken toggling: each enabled-cycle value lasts two clocks.
    kick(16'd100, 16'd130, 16'd10, 16'd2, 1'b0);
    push(16'd100, 3, 1'b1, 1'b0);
    push(16'd110, 3, 1'b1, 1'b0);
    push(16'd120, 3, 1'b1, 1'b0);
    push(16'd130, 3, 1'b1, 1'b0);
    push(16'd130, 1, 1'b0, 1'b1);
    push(16'd130, 1, 1'b0, 1'b0);
    drain("gated", 1'b1);

    // Repeat mode, then abort while at 20.
    kick(16'd10, 16'd20, 16'd10, 16'd0, 1'b1);
    push(16'd10, 1, 1'b1, 1'b0);
    push(16'd20, 1, 1'b1, 1'b0);
    push(16'd10, 1, 1'b1, 1'b1);
    push(16'd20, 1, 1'b1, 1'b0);
    push(16'd10, 1, 1'b1, 1'b1);
    drain("rpt", 1'b0);
    chk("rpt.last.phi", 32'(phi_inc_o), 32'd20);
    chk("rpt.last.busy", 32'(busy), 32'h1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort.phi", 32'(phi_inc_o), 32'd20);
    chk("abort.busy", 32'(busy), 32'h0);
    chk("abort.done", 32'(done), 32'h0);
    @(posedge clk);
    #1;
    chk("abort.idle.phi", 32'(phi_inc_o), 32'd20);
    chk("abort.idle.busy", 32'(busy), 32'h0);
    chk("abort.idle.done", 32'(done), 32'h0);

    // abort beats start in IDLE.
    start_inc = 16'd300;
    stop_inc  = 16'd400;
    step_inc  = 16'd50;
    dwell     = 16'd0;
    start     = 1'b1;
    abort     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abst.busy", 32'(busy), 32'h0);
    chk("abst.phi", 32'(phi_inc_o), 32'd20);
    @(posedge clk);
    #1;
    chk("abst.busy2", 32'(busy), 32'h0);

    // Asynchronous reset in the middle of a down-sweep.
    kick(16'd500, 16'd480, 16'd7, 16'd2, 1'b0);
    push(16'd500, 3, 1'b1, 1'b0);
    push(16'd493, 1, 1'b1, 1'b0);
    drain("prerst", 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk("arst.phi", 32'(phi_inc_o), 32'h0);
    chk("arst.busy", 32'(busy), 32'h0);
    chk("arst.done", 32'(done), 32'h0);
    chk("arst.dir", 32'(dir_o), 32'h1);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst.phi", 32'(phi_inc_o), 32'h0);
    chk("postrst.busy", 32'(busy), 32'h0);
    kick(16'd500, 16'd480, 16'd7, 16'd0, 1'b0);
    push(16'd500, 1, 1'b1, 1'b0);
    push(16'd493, 1, 1'b1, 1'b0);
    push(16'd486, 1, 1'b1, 1'b0);
    push(16'd480, 1, 1'b1, 1'b0);
    push(16'd480, 1, 1'b0, 1'b1);
    push(16'd480, 1, 1'b0, 1'b0);
    drain("restart", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Phase-increment sequencer upstream of the NCO: drives phi_inc_i of nco_st with a stepped linear frequency sweep (chirp) from start_inc to stop_inc.
Each frequency is held for a programmable dwell.
Advances only on the same clken that gates the NCO, so sweep timing is in NCO sample periods.
Supports single-shot and repeat modes, abort, and busy/done status for the host controller.

Parameters:
apr, 16, phase-increment width; must equal nco_st apr
dwr, 16, dwell counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clken  in  1  NCO clock enable; state, counters and outputs update only when high
start  in  1  start pulse; sampled only in IDLE with clken high
abort  in  1  stop sweep; sampled with clken high; priority over start/step
rpt  in  1  repeat mode, latched at start
start_inc  in  apr  first phase increment (unsigned), latched at start
stop_inc  in  apr  final phase increment (unsigned), latched at start
step_inc  in  apr  increment magnitude per step (unsigned), latched at start
dwell  in  dwr  hold count; each frequency lasts dwell+1 enabled cycles
phi_inc_o  out  apr  phase increment to nco_st phi_inc_i, registered
busy  out  1  high in SWEEP
done  out  1  one enabled-cycle pulse at end of each pass
dir_o  out  1  1 = up-sweep (start_inc <= stop_inc), 0 = down; registered at start

Behaviour:
- Reset (async, any time): state IDLE; phi_inc_o = 0; busy = 0; done = 0; dir_o = 1; dwell counter = 0.
- clken low: all registers hold, including done. done is therefore high for exactly one clken-high cycle.
- States: IDLE, SWEEP, LAST.
- IDLE, start = 1, clken = 1 at cycle N:
  - latch all inputs; dir = (start_inc <= stop_inc);
  - at the next enabled edge, phi_inc_o = start_inc, busy = 1, dwell counter = dwell, go to SWEEP.
- IDLE: start while busy is ignored. phi_inc_o holds its last value (no return to 0).
- SWEEP, each enabled cycle:
  - if counter != 0, decrement.
  - else compute next = cur + step (up) or cur - step (down) in apr+1 bits.
  - Clamp next to stop_inc if it passes stop_inc, or on carry/borrow (no wrap-around ever).
  - Load phi_inc_o = next and reload counter = dwell.
  - If next == stop_inc, go to LAST.
- start_inc == stop_inc: go directly to LAST after the first dwell.
- step_inc == 0: treated as a single jump to stop_inc after the first dwell.
- LAST: hold stop_inc for dwell+1 enabled cycles, then pulse done.
  - rpt = 0: go to IDLE, busy = 0, phi_inc_o stays at stop_inc.
  - rpt = 1: phi_inc_o = start_inc, counter = dwell, stay busy, go to SWEEP.
  - A pass therefore spans (number of distinct frequencies) × (dwell+1) enabled cycles.
- abort (clken high, any state): next enabled edge goes to IDLE, busy = 0, no done pulse, phi_inc_o holds its current value.
- abort and start in the same cycle in IDLE: abort wins, sweep does not start.
- Latched parameters are immune to input changes during a sweep.

Decomposition:
- Shared package nco_sweep_pkg holds:
  - state encoding localparams S_IDLE = 2'd0, S_SWEEP = 2'd1, S_LAST = 2'd2;
  - the clamp function (next value, stop, dir, carry) -> clamped value, reused by any future hop controller.
- One sub-module: nco_sweep_dwell_cnt.
  - Loadable down-counter with clken, load, and zero flag; width dwr.
- FSM and step arithmetic stay in nco_sweep_ctrl.

Test Plan:
- Up-sweep: start 100 → 130, step 10, dwell 2, rpt 0, clken = 1.
  - phi_inc_o = 100,100,100,110,110,110,120,120,120,130,130,130.
  - Then one-cycle done; busy falls; phi_inc_o stays 130.
- Overshoot clamp: 100 → 125, step 10, dwell 0 → sequence 100,110,120,125; done on the cycle after 125.
- Down and no-wrap:
  - 500 → 480, step 7, dwell 0 → 500,493,486,480, dir_o = 0.
  - 0xFFF0 → 0xFFFF, step 0x20 → 0xFFF0, 0xFFFF, never 0x0010.
- clken gating: first case with clken toggling 1,0,1,0.
  - Each value is held 3 enabled cycles (6 clocks).
  - done lasts through the intervening clken-low cycle.
- Repeat and abort:
  - rpt = 1, 10 → 20, step 10, dwell 0 → 10,20,(done),10,20,(done),…
  - abort while at 20 → IDLE next enabled edge, phi_inc_o = 20, no done.
- Reset mid-sweep: assert reset asynchronously between clock edges.
  - Outputs go 0 immediately.
  - After release, start is accepted and the sweep restarts from start_inc.
